// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM states, the lookahead
// group size and the width rounding used to size lookahead datapaths.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_e;

    localparam int CLA_GROUP = 4;

    // Round a datapath width up to a whole number of lookahead groups.
    function automatic int cla_width(input int n);
        return ((n + CLA_GROUP - 1) / CLA_GROUP) * CLA_GROUP;
    endfunction

endpackage

// File: rtl/borrow_lookahead_subtractor.sv
// Combinational a - b built as a + ~b + 1 from 4-bit lookahead groups in
// series; borrow is the inverted final carry.
module lookahead_group4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

module borrow_lookahead_subtractor
    import arith_pkg::*;
#(
    parameter int N = 20
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int NG = N / CLA_GROUP;

    logic [N-1:0] b_inv;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [NG:0]  gc;

    assign b_inv  = ~b;
    assign g      = a & b_inv;
    assign p      = a ^ b_inv;
    assign gc[0]  = 1'b1;
    assign borrow = ~gc[NG];

    for (genvar i = 0; i < NG; i++) begin : g_grp
        lookahead_group4 u_grp (
            .g    (g[i*CLA_GROUP +: CLA_GROUP]),
            .p    (p[i*CLA_GROUP +: CLA_GROUP]),
            .cin  (gc[i]),
            .sum  (diff[i*CLA_GROUP +: CLA_GROUP]),
            .cout (gc[i+1])
        );
    end

endmodule

// File: rtl/cla_restoring_divider.sv
// Iterative unsigned restoring divider, one trial subtraction per clock via the
// borrow-lookahead subtractor; start/busy/done handshake with held results.
module cla_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int SW    = cla_width(WIDTH + 4);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH:0]   trial;
    logic [SW-1:0]    sub_a;
    logic [SW-1:0]    sub_b;
    logic [SW-1:0]    sub_diff;
    logic             sub_borrow;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;

    assign trial = {rem_r, q_r[WIDTH-1]};
    assign sub_a = {{(SW-WIDTH-1){1'b0}}, trial};
    assign sub_b = {{(SW-WIDTH){1'b0}}, dvs_r};

    borrow_lookahead_subtractor #(
        .N (SW)
    ) u_sub (
        .a      (sub_a),
        .b      (sub_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // The partial remainder always stays below the divisor, so a kept
    // difference has zero upper bits and R fits in WIDTH bits.
    assign take    = ~sub_borrow & ~|sub_diff[SW-1:WIDTH];
    assign rem_nxt = take ? sub_diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_nxt   = {q_r[WIDTH-2:0], take};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rem_r       <= '0;
            q_r         <= '0;
            dvs_r       <= '0;
            cnt_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        q_r         <= dividend;
                        dvs_r       <= divisor;
                        rem_r       <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= FINISH;
                        end else begin
                            cnt_r <= CNT_W'(WIDTH);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_r <= rem_nxt;
                    q_r   <= q_nxt;
                    cnt_r <= cnt_r - 1'b1;
                    if (cnt_r == CNT_W'(1)) begin
                        quotient  <= q_nxt;
                        remainder <= rem_nxt;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cla_restoring_divider.md
Name: cla_restoring_divider

Overview:
- Iterative unsigned restoring divider. It performs one trial subtraction per clock through a borrow-lookahead subtractor built from 4-bit lookahead groups.
- Subtraction is the inverse direction of the existing carry-lookahead adder path, and this block is the team's divide unit in the arithmetic library.
- Handshake is start/busy/done. Results stay registered until the next accepted start.

Parameters:
- WIDTH, 16, dividend/divisor/quotient/remainder width. Must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  unsigned, captured on accepted start
- divisor  input  WIDTH  unsigned, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive of neither
- done  output  1  single-cycle pulse when results become valid
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered flag, valid with done, held with results

Behaviour:
- Reset (async assert, sync to clk on release):
  - FSM goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal partial remainder, shift register and counter are cleared.
  - A reset during RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: start=1 captures both operands and clears div_by_zero.
    - If divisor==0, go to FINISH with quotient forced to all ones, remainder=dividend, div_by_zero=1 (done 1 cycle after start).
    - Otherwise load R=0 (WIDTH+1 bits), Q=dividend, count=WIDTH, and go to RUN.
  - RUN: each cycle:
    - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
    - D = T - {0, divisor} via the subtractor.
    - If no borrow: R=D and shift 1 into Q. Otherwise R=T and shift 0 into Q.
    - Decrement count. When count reaches 1 on this step, go to FINISH.
  - FINISH: drive quotient=Q and remainder=R[WIDTH-1:0], pulse done=1 for this cycle, then return to IDLE.
- Latency: start accepted at edge k, done high during cycle k+WIDTH+1 (17 cycles for WIDTH=16). Divide-by-zero has done at cycle k+1.
- busy=1 exactly while in RUN.
- start while busy or in FINISH is ignored; there is no queueing. A start in the first IDLE cycle after done is accepted.
- Outputs hold their last values through IDLE. quotient/remainder update only in FINISH.
- Arithmetic:
  - Operands are zero-extended to SW = WIDTH+4 bits for the subtractor.
  - The subtraction is A + ~B + 1.
  - Borrow = NOT carry-out.
- Subtractor internal structure:
  - Per bit: g=a&~b, p=a^~b.
  - Within a 4-bit group, carries use full lookahead equations (c1..c4 from g,p,cin); group carry-out feeds the next group's cin.
  - First cin=1.
  - Sum bits = p ^ c.
  - The subtractor is purely combinational.
- No X-propagation: all registers have defined reset values; operands are not used outside accepted starts.

Decomposition:
- Shared package arith_pkg:
  - FSM state enum {IDLE, RUN, FINISH}.
  - Constant CLA_GROUP=4.
  - Function ceil-to-group-multiple for subtractor width.
- Natural sub-module: borrow_lookahead_subtractor (parameter N, multiple of 4).
  - Inputs a[N], b[N]; outputs diff[N], borrow.
  - Internally instantiates N/4 four-bit lookahead groups in series.
  - The divider instantiates it once with N=WIDTH+4.
  - The subtractor gets its own unit bench: exhaustive for N=4, random for N=20.

Test Plan:
- 100/7 (WIDTH=16): start pulse → busy for 16 cycles, done at cycle 17, quotient=14, remainder=2, div_by_zero=0.
- 0xFFFF/0x0001 and 0x1234/0xFFFF: results (0xFFFF, 0) and (0, 0x1234); dividend<divisor path leaves quotient 0.
- Divide by zero, 0xBEEF/0: done at cycle 1, quotient=0xFFFF, remainder=0xBEEF, div_by_zero=1. A following 9/3 clears the flag, giving (3, 0).
- Start asserted continuously with changing operands during RUN of 50/5: result (10, 0), unaffected. Next operation starts the cycle after done; outputs hold between operations.
- rst asserted mid-RUN (cycle 8 of 60000/7): all outputs 0 immediately (async), no done pulse. A subsequent 60000/7 yields (8571, 3).
- Random 10k operand pairs vs. reference model, including divisor=1, divisor=dividend and max values. Check the done-pulse width is exactly 1 and busy/done are never high together.
